// File: rtl/rtsnoc_pkg.sv
// ============================================================================
// Module      : rtsnoc_pkg
// Description : Shared definitions for the RTSNoC local-port arbiter: flit
//               width helper, header-field offsets, local address width and
//               the transmit/receive FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtsnoc_pkg;

  // Width of every local-address field (orig_local / dst_local).
  localparam int LADDR_W = 3;

  // Full flit width:
  //   orig_x | orig_y | orig_local | dst_x | dst_y | dst_local | data
  function automatic int bus_width(input int ndw, input int sx, input int sy);
    return ndw + 2 * sx + 2 * sy + 2 * LADDR_W;
  endfunction

  // LSB position of dst_local (sits directly above the payload).
  function automatic int dst_local_lsb(input int ndw);
    return ndw;
  endfunction

  // LSB position of orig_local (above dst_local, dst_y and dst_x).
  function automatic int orig_local_lsb(input int ndw, input int sx, input int sy);
    return ndw + LADDR_W + sx + sy;
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HOLD = 2'd1,
    RX_GAP  = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rtsnoc_local_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rtsnoc_rr_arbiter
// Description : Round-robin priority picker. The search starts at
//               last_grant+1 (mod N) and wraps; last_grant itself has the
//               lowest priority.
// Ports       : req         - request vector
//               last_grant  - index of the previous winner
//               grant       - one-hot grant
//               grant_idx   - binary index of the granted requester
//               grant_valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtsnoc_rr_arbiter
  import rtsnoc_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_idx,
  output logic          grant_valid
);

  // Walk offsets 1..N away from last_grant; the first requester found wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int j = 0; j < N; j++) begin
        if (!grant_valid && req[j] && (((int'(last_grant) + off) % N) == j)) begin
          grant_valid = 1'b1;
          grant[j]    = 1'b1;
          grant_idx   = CW'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rtsnoc_local_port_arbiter.sv
// ============================================================================
// Module      : rtsnoc_local_port_arbiter
// Description : Shares one RTSNoC router local port among NUM_CLIENTS proxy
//               clients. Transmit flits are arbitrated round-robin onto the
//               router din/wr/wait interface; received flits are steered to
//               the client selected by the sender's orig_local field.
// Config      : RTSNOC_ARB_BURST_EN - when defined, a client that still
//               requests right after an accept keeps the grant for up to
//               BURST_LEN consecutive accepts.
// Ports       : clk_i, rst_n_i         - clock, async active-low reset
//               cl_din_i/cl_wr_i       - per-client transmit flit/request
//               cl_wait_o              - 0 = client flit accepted this cycle
//               cl_dout_o/cl_nd_o      - received flit / per-client valid
//               cl_rd_i                - per-client consume strobe
//               noc_din_o/noc_wr_o     - flit/strobe to the router
//               noc_wait_i             - router busy
//               noc_dout_i/noc_nd_i    - flit/new-data from the router
//               noc_rd_o               - router read strobe
//               rx_drop_o              - pulse when a received flit is dropped
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtsnoc_local_port_arbiter
  import rtsnoc_pkg::*;
#(
  parameter int  NUM_CLIENTS    = 4,
  parameter int  SOC_SIZE_X     = 1,
  parameter int  SOC_SIZE_Y     = 1,
  parameter int  NOC_DATA_WIDTH = 16,
  parameter int  BURST_LEN      = 4,
  localparam int BUS = bus_width(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y),
  localparam int CW  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_CLIENTS*BUS-1:0] cl_din_i,
  input  logic [NUM_CLIENTS-1:0]     cl_wr_i,
  output logic [NUM_CLIENTS-1:0]     cl_wait_o,
  output logic [BUS-1:0]             cl_dout_o,
  output logic [NUM_CLIENTS-1:0]     cl_nd_o,
  input  logic [NUM_CLIENTS-1:0]     cl_rd_i,
  output logic [BUS-1:0]             noc_din_o,
  output logic                       noc_wr_o,
  input  logic                       noc_wait_i,
  input  logic [BUS-1:0]             noc_dout_i,
  input  logic                       noc_nd_i,
  output logic                       noc_rd_o,
  output logic                       rx_drop_o
);

  localparam int ORIG_LSB = orig_local_lsb(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);

  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || BURST_LEN < 1) begin : g_param_err
    $error("rtsnoc_local_port_arbiter: NUM_CLIENTS must be 2..8 and BURST_LEN >= 1");
  end

  // --------------------------------------------------------------------------
  // Transmit path
  // --------------------------------------------------------------------------
  tx_state_t              tx_state, tx_state_nxt;
  logic [BUS-1:0]         tx_reg;
  logic [CW-1:0]          last_grant;
  logic [NUM_CLIENTS-1:0] rr_grant;
  logic [CW-1:0]          rr_idx;
  logic                   rr_valid;
  logic                   burst_keep;
  logic [CW-1:0]          win_idx;
  logic [NUM_CLIENTS-1:0] win_onehot;
  logic [BUS-1:0]         win_flit;
  logic                   accept;

  rtsnoc_rr_arbiter #(
    .N  (NUM_CLIENTS),
    .CW (CW)
  ) u_rr (
    .req         (cl_wr_i),
    .last_grant  (last_grant),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  // Gating with rst_n_i keeps every output at its reset value while reset is
  // held, even though these strobes are combinational from the inputs.
  assign accept  = rst_n_i && (tx_state == TX_IDLE) && rr_valid && !noc_wait_i;
  assign win_idx = burst_keep ? last_grant : rr_idx;

`ifdef RTSNOC_ARB_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);
  logic [BCW-1:0] burst_cnt;

  // burst_cnt counts consecutive accepts of last_grant; zero means no burst
  // is running (after reset or after a TX_IDLE cycle without an accept).
  assign burst_keep = (burst_cnt != '0) && (int'(burst_cnt) < BURST_LEN) &&
                      cl_wr_i[last_grant];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_cnt <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (accept) begin
        burst_cnt <= burst_keep ? (burst_cnt + BCW'(1)) : BCW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end
`else
  assign burst_keep = 1'b0;
`endif

  always_comb begin
    win_onehot = '0;
    win_flit   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (win_idx == CW'(k)) begin
        win_onehot[k] = 1'b1;
        win_flit      = cl_din_i[k*BUS +: BUS];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_state_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    noc_wr_o     = 1'b0;
    cl_wait_o    = '1;
    case (tx_state)
      TX_IDLE: begin
        if (accept) begin
          cl_wait_o    = ~win_onehot;
          tx_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        noc_wr_o     = 1'b1;
        tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_reg     <= '0;
      last_grant <= CW'(NUM_CLIENTS - 1);
    end else if (accept) begin
      tx_reg     <= win_flit;
      last_grant <= win_idx;
    end
  end

  assign noc_din_o = tx_reg;

  // --------------------------------------------------------------------------
  // Receive path
  // --------------------------------------------------------------------------
  rx_state_t            rx_state, rx_state_nxt;
  logic [BUS-1:0]       rx_reg;
  logic [CW-1:0]        rx_tgt;
  logic [LADDR_W-1:0]   in_local;
  logic                 in_valid;
  logic                 rx_take;

  assign in_local = noc_dout_i[ORIG_LSB +: LADDR_W];
  assign in_valid = int'(in_local) < NUM_CLIENTS;
  assign rx_take  = rst_n_i && (rx_state == RX_IDLE) && noc_nd_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    noc_rd_o     = 1'b0;
    rx_drop_o    = 1'b0;
    cl_nd_o      = '0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_take) begin
          noc_rd_o = 1'b1;
          if (in_valid) begin
            rx_state_nxt = RX_HOLD;
          end else begin
            rx_drop_o    = 1'b1;
            rx_state_nxt = RX_GAP;
          end
        end
      end
      RX_HOLD: begin
        cl_nd_o[rx_tgt] = 1'b1;
        if (cl_rd_i[rx_tgt]) begin
          rx_state_nxt = RX_GAP;
        end
      end
      // One dead cycle lets the router drop noc_nd_i before it is sampled again.
      RX_GAP:  rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_reg <= '0;
      rx_tgt <= '0;
    end else if (rx_take && in_valid) begin
      rx_reg <= noc_dout_i;
      rx_tgt <= CW'(in_local);
    end
  end

  assign cl_dout_o = rx_reg;

endmodule

`default_nettype wire

// File: tb/tb_rtsnoc_local_port_arbiter.sv
`default_nettype none

module tb_rtsnoc_local_port_arbiter;

  localparam int N      = 4;
  localparam int SX     = 1;
  localparam int SY     = 1;
  localparam int NDW    = 16;
  localparam int BL     = 4;
  localparam int BUS    = NDW + 2*SX + 2*SY + 6;
  localparam int OL_LSB = NDW + 3 + SX + SY;
`ifdef RTSNOC_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*BUS-1:0] cl_din_i;
  logic [N-1:0]     cl_wr_i;
  logic [N-1:0]     cl_wait_o;
  logic [BUS-1:0]   cl_dout_o;
  logic [N-1:0]     cl_nd_o;
  logic [N-1:0]     cl_rd_i;
  logic [BUS-1:0]   noc_din_o;
  logic             noc_wr_o;
  logic             noc_wait_i;
  logic [BUS-1:0]   noc_dout_i;
  logic             noc_nd_i;
  logic             noc_rd_o;
  logic             rx_drop_o;

  always #5 clk = ~clk;

  rtsnoc_local_port_arbiter #(
    .NUM_CLIENTS    (N),
    .SOC_SIZE_X     (SX),
    .SOC_SIZE_Y     (SY),
    .NOC_DATA_WIDTH (NDW),
    .BURST_LEN      (BL)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .cl_din_i   (cl_din_i),
    .cl_wr_i    (cl_wr_i),
    .cl_wait_o  (cl_wait_o),
    .cl_dout_o  (cl_dout_o),
    .cl_nd_o    (cl_nd_o),
    .cl_rd_i    (cl_rd_i),
    .noc_din_o  (noc_din_o),
    .noc_wr_o   (noc_wr_o),
    .noc_wait_i (noc_wait_i),
    .noc_dout_i (noc_dout_i),
    .noc_nd_i   (noc_nd_i),
    .noc_rd_o   (noc_rd_o),
    .rx_drop_o  (rx_drop_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stimulus state
  bit             req [N];
  logic [BUS-1:0] flit[N];
  bit             dir_mode;
  bit             force_wait;
  logic [N-1:0]   force_rd;
  logic [N-1:0]   dir_mask;
  bit             rt_valid;
  logic [BUS-1:0] rt_flit;

  // Reference model: what the port is doing, in transaction terms
  bit             m_tx_busy;   // an accepted flit goes out this cycle
  logic [BUS-1:0] m_tx_flit;   // last flit handed to the router
  int             m_last;      // last granted client
  int             m_run;       // consecutive accepts of m_last
  bit             m_hold;      // a received flit is offered to m_tgt
  int             m_tgt;
  bit             m_gap;       // one dead cycle after a receive completes
  logic [BUS-1:0] m_rx_flit;

  // Observations
  int obs_acc[$];
  int wr_seen, rd_seen, drop_seen, nd_cnt;

  function automatic logic [BUS-1:0] make_flit(input int ol);
    logic [63:0]    r;
    logic [BUS-1:0] f;
    r = {$urandom(), $urandom()};
    f = r[BUS-1:0];
    f[OL_LSB +: 3] = ol[2:0];
    return f;
  endfunction

  task automatic clear_obs();
    obs_acc.delete();
    wr_seen = 0; rd_seen = 0; drop_seen = 0; nd_cnt = 0;
  endtask

  task automatic model_reset();
    m_tx_busy = 0; m_tx_flit = '0; m_last = N - 1; m_run = 0;
    m_hold = 0; m_tgt = 0; m_gap = 0; m_rx_flit = '0;
    for (int k = 0; k < N; k++) begin
      req[k] = 0; flit[k] = '0;
    end
    rt_valid = 0; rt_flit = '0;
    dir_mode = 0; force_wait = 0; force_rd = '0; dir_mask = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_cl_wait"}, cl_wait_o, {N{1'b1}});
    check_eq({pfx, "_noc_wr"},  noc_wr_o,  0);
    check_eq({pfx, "_noc_rd"},  noc_rd_o,  0);
    check_eq({pfx, "_drop"},    rx_drop_o, 0);
    check_eq({pfx, "_cl_nd"},   cl_nd_o,   0);
    check_eq({pfx, "_noc_din"}, noc_din_o, 0);
    check_eq({pfx, "_cl_dout"}, cl_dout_o, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cl_wr_i = '0; cl_din_i = '0; noc_wait_i = 1'b0;
    noc_dout_i = '0; noc_nd_i = 1'b0; cl_rd_i = '0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  task automatic start_dir(input logic [N-1:0] mask, input bit wt);
    dir_mode = 1; dir_mask = mask; force_wait = wt; force_rd = '0;
    for (int k = 0; k < N; k++) begin
      req[k]  = mask[k];
      flit[k] = make_flit(k);
    end
  endtask

  // One clock cycle: drive inputs after the edge, predict and check before
  // the next edge, then advance model and stimulus.
  task automatic step();
    logic [N-1:0] wr_vec, exp_wait, exp_nd;
    int  win, ol;
    bit  acc, keep, exp_rd, exp_drop;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      wr_vec[k] = req[k];
      cl_din_i[k*BUS +: BUS] = flit[k];
    end
    cl_wr_i    = wr_vec;
    noc_wait_i = dir_mode ? force_wait : ($urandom_range(0, 3) == 0);
    noc_nd_i   = rt_valid;
    noc_dout_i = rt_flit;
    cl_rd_i    = dir_mode ? force_rd : N'($urandom());
    @(negedge clk);

    acc = 0; keep = 0; win = -1; exp_wait = '1;
    if (!m_tx_busy && wr_vec != '0 && !noc_wait_i) begin
      keep = BURST && m_run > 0 && m_run < BL && wr_vec[m_last];
      if (keep) win = m_last;
      else
        for (int i = 1; i <= N; i++)
          if (win < 0 && wr_vec[(m_last + i) % N]) win = (m_last + i) % N;
      acc = 1;
      exp_wait[win] = 1'b0;
    end
    check_eq("cl_wait", cl_wait_o, exp_wait);
    check_eq("noc_wr",  noc_wr_o,  m_tx_busy);
    check_eq("noc_din", noc_din_o, m_tx_flit);

    ol       = int'(rt_flit[OL_LSB +: 3]);
    exp_rd   = rt_valid && !m_hold && !m_gap;
    exp_drop = exp_rd && ol >= N;
    exp_nd   = m_hold ? (N'(1) << m_tgt) : '0;
    check_eq("noc_rd",  noc_rd_o,  exp_rd);
    check_eq("drop",    rx_drop_o, exp_drop);
    check_eq("cl_nd",   cl_nd_o,   exp_nd);
    check_eq("cl_dout", cl_dout_o, m_rx_flit);

    for (int k = 0; k < N; k++)
      if (wr_vec[k] && !cl_wait_o[k]) obs_acc.push_back(k);
    wr_seen   += int'(noc_wr_o);
    rd_seen   += int'(noc_rd_o);
    drop_seen += int'(rx_drop_o);
    nd_cnt    += int'(cl_nd_o != '0);

    if (m_tx_busy) m_tx_busy = 0;
    else if (acc) begin
      m_run     = keep ? m_run + 1 : 1;
      m_last    = win;
      m_tx_flit = flit[win];
      m_tx_busy = 1;
    end else m_run = 0;

    if (exp_rd) begin
      if (ol < N) begin
        m_hold = 1; m_tgt = ol; m_rx_flit = rt_flit;
      end else m_gap = 1;
      rt_valid = 0;
    end else if (m_hold) begin
      if (cl_rd_i[m_tgt]) begin
        m_hold = 0; m_gap = 1;
      end
    end else if (m_gap) m_gap = 0;

    for (int k = 0; k < N; k++) begin
      if (acc && win == k) begin
        flit[k] = make_flit(k);
        req[k]  = dir_mode ? dir_mask[k] : 1'($urandom_range(0, 1));
      end else if (!req[k] && !dir_mode && $urandom_range(0, 2) == 0) begin
        req[k]  = 1;
        flit[k] = make_flit($urandom_range(0, 7));
      end
    end
    if (!dir_mode && !rt_valid && !exp_rd && $urandom_range(0, 2) == 0) begin
      rt_valid = 1;
      rt_flit  = make_flit($urandom_range(0, 7));
    end
  endtask

  task automatic check_seq(input string tag, input int exp[]);
    check_eq({tag, "_len"}, obs_acc.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check_eq($sformatf("%s[%0d]", tag, i), (i < obs_acc.size()) ? obs_acc[i] : 99, exp[i]);
  endtask

  initial begin
    int seq_a[];
    int seq_b[];
    if (BURST) begin
      seq_a = '{0, 0, 0, 0, 1};
      seq_b = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    end else begin
      seq_a = '{0, 1, 2, 3, 0};
      seq_b = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    end

    // Idle after reset
    do_reset();
    repeat (4) step();

    // All four clients request
    do_reset();
    start_dir(4'b1111, 0);
    repeat (10) step();
    check_seq("seqA", seq_a);
    check_eq("seqA_wr_pulses", wr_seen, 5);

    // Clients 0 and 1 request continuously
    do_reset();
    start_dir(4'b0011, 0);
    repeat (18) step();
    check_seq("seqB", seq_b);

    // Router busy for 10 cycles with client 2 requesting
    do_reset();
    start_dir(4'b0100, 1);
    repeat (10) step();
    check_eq("wait_no_accept", obs_acc.size(), 0);
    check_eq("wait_no_wr", wr_seen, 0);
    force_wait = 0;
    dir_mask   = '0;
    repeat (2) step();
    check_seq("wait_release", '{2});
    check_eq("release_wr", wr_seen, 1);

    // Receive for client 2; a read from client 1 is ignored
    do_reset();
    start_dir('0, 0);
    rt_valid = 1; rt_flit = make_flit(2);
    force_rd = 4'b0010;
    repeat (3) step();
    force_rd = 4'b0100;
    repeat (3) step();
    check_eq("rx2_rd_pulses", rd_seen, 1);
    check_eq("rx2_drops", drop_seen, 0);
    check_eq("rx2_nd_cycles", nd_cnt, 3);

    // Receive for nonexistent client 6 is dropped
    do_reset();
    start_dir('0, 0);
    rt_valid = 1; rt_flit = make_flit(6);
    repeat (4) step();
    check_eq("rx6_rd_pulses", rd_seen, 1);
    check_eq("rx6_drops", drop_seen, 1);
    check_eq("rx6_nd_cycles", nd_cnt, 0);

    // Random traffic, then an asynchronous reset in the middle of it
    do_reset();
    repeat (300) step();
    @(posedge clk);
    #2;
    cl_wr_i = '1; noc_nd_i = 1'b1; noc_dout_i = make_flit(1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    do_reset();
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
